square_meter: RTL

//  Measures the period and high time of a square wave, e.g. the output of the threshold-based

---
 rtl/square_meter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/square_meter.sv
// square_meter: measures period and high time of an asynchronous square wave,
// averaged over 2^AVG_LOG2 consecutive periods, in clk_100M cycles.
module square_meter #(
   parameter int CNT_W    = 32,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 100_000_000
) (
   input  logic             clk_100M,
   input  logic             rst,
   input  logic             square,
   input  logic             start,
   input  logic             cont,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             busy,
   output logic             timeout
);

   localparam int                EDGE_W  = 9;
   localparam logic [EDGE_W-1:0] N_EDGES = EDGE_W'(1 << AVG_LOG2);
   localparam logic [CNT_W-1:0]  TMO_LIM = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   state_t            state_q;
   state_t            state_d;
   logic              sq_p0;
   logic              sq_p1;
   logic              sq_p2;
   logic              rise;
   logic              arm_hit;
   logic              done;
   logic              tmo;
   logic [CNT_W-1:0]  period_acc;
   logic [CNT_W-1:0]  high_acc;
   logic [CNT_W-1:0]  gap_cnt;
   logic [CNT_W-1:0]  gap_nxt;
   logic [EDGE_W-1:0] edge_cnt;
   logic [EDGE_W-1:0] edge_nxt;

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{CNT_W{1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // Input stages: p0/p1 synchronise, p2 delays by one for edge detection.
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         sq_p0 <= 1'b0;
         sq_p1 <= 1'b0;
         sq_p2 <= 1'b0;
      end else begin
         sq_p0 <= square;
         sq_p1 <= sq_p0;
         sq_p2 <= sq_p1;
      end
   end

   assign rise     = sq_p1 & ~sq_p2;
   assign gap_nxt  = sat_add(gap_cnt, 1'b1);
   assign edge_nxt = edge_cnt + 1'b1;
   assign busy     = (state_q == ARM) || (state_q == MEAS);

   // State register.
   always_ff @(posedge clk_100M) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a start coinciding with a result pulse is dropped.
   always_comb begin
      state_d = state_q;
      arm_hit = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !valid) state_d = ARM;
         end
         ARM: begin
            if (rise) begin
               arm_hit = 1'b1;
               state_d = MEAS;
            end else if (gap_nxt >= TMO_LIM) begin
               tmo     = 1'b1;
               state_d = IDLE;
            end
         end
         MEAS: begin
            if (rise) begin
               if (edge_nxt == N_EDGES) begin
                  done    = 1'b1;
                  state_d = cont ? MEAS : IDLE;
               end
            end else if (gap_nxt >= TMO_LIM) begin
               tmo     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Accumulators and result registers. A restarting rise counts as the first
   // cycle of the new period; sq_p2 is always 0 on a rise so high_acc starts at 0.
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         period     <= '0;
         high_time  <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
         period_acc <= '0;
         high_acc   <= '0;
         gap_cnt    <= '0;
         edge_cnt   <= '0;
      end else begin
         valid   <= done;
         timeout <= tmo;
         if (done) begin
            period    <= period_acc >> AVG_LOG2;
            high_time <= high_acc >> AVG_LOG2;
         end
         if (state_q == IDLE || rise) gap_cnt <= '0;
         else                         gap_cnt <= gap_nxt;
         if (arm_hit || done) begin
            period_acc <= {{(CNT_W-1){1'b0}}, 1'b1};
            high_acc   <= '0;
            edge_cnt   <= '0;
         end else if (state_q == MEAS) begin
            period_acc <= sat_add(period_acc, 1'b1);
            high_acc   <= sat_add(high_acc, sq_p2);
            if (rise) edge_cnt <= edge_nxt;
         end
      end
   end

endmodule
